// File: rtl/sliding_window_gen_if.sv
// Valid/ready stream bundle, used for both the pixel input and the window output.
interface sliding_window_gen_if #(
  parameter int DATA_BITS = 16
);
  logic                 tvalid;
  logic                 tready;
  logic [DATA_BITS-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/sliding_window_gen.sv
// Streaming KxK sliding-window generator: keeps K-1 image rows and the last K-1
// columns per channel fold, and emits one wide window beat per completed window.
module sliding_window_gen #(
  parameter int IFM_DIM_X    = 8,
  parameter int IFM_DIM_Y    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int SIMD         = 2,
  parameter int ELEM_BITS    = 8,
  parameter int K            = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  sliding_window_gen_if.slave  s_axis,
  sliding_window_gen_if.master m_axis
);
  localparam int SF          = NUM_CHANNELS / SIMD;
  localparam int PIX         = SIMD * ELEM_BITS;
  localparam int STREAM_BITS = 8 * ((PIX + 7) / 8);
  localparam int OUT_BITS    = 8 * ((K * K * PIX + 7) / 8);

  generate
    if (K < 1 || K > IFM_DIM_X || K > IFM_DIM_Y) begin : g_bad_k
      $error("sliding_window_gen: K=%0d must satisfy 1 <= K <= min(W,H)", K);
    end
    if (NUM_CHANNELS % SIMD != 0) begin : g_bad_simd
      $error("sliding_window_gen: NUM_CHANNELS must be a multiple of SIMD");
    end
  endgenerate

  logic                s_ready;
  logic                accept;
  logic                accept_w;
  logic                emit;
  logic [PIX-1:0]      pix_in;
  logic [OUT_BITS-1:0] window;
  logic                m_valid_q;
  logic [OUT_BITS-1:0] m_data_q;

  assign s_ready       = !m_valid_q || m_axis.tready;
  assign s_axis.tready = s_ready;
  assign accept        = s_axis.tvalid && s_ready;
  assign accept_w      = accept && !rst;
  assign pix_in        = s_axis.tdata[PIX-1:0];
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = m_data_q;

  // Single output register; an accepted beat either reloads it or empties it.
  always_ff @(posedge clk) begin
    if (rst)
      m_valid_q <= 1'b0;
    else if (accept)
      m_valid_q <= emit;
    else if (m_axis.tready)
      m_valid_q <= 1'b0;
    if (emit)
      m_data_q <= window;
  end

  generate
    if (K == 1) begin : g_k1
      assign emit   = accept_w;
      assign window = OUT_BITS'(pix_in);
    end else begin : g_kn
      localparam int LB_DEPTH   = IFM_DIM_X * SF;
      localparam int SW         = (SF > 1) ? $clog2(SF) : 1;
      localparam int XW         = $clog2(IFM_DIM_X);
      localparam int YW         = $clog2(IFM_DIM_Y);
      localparam int AW         = $clog2(LB_DEPTH);
      localparam int COL_BITS   = K * PIX;
      localparam int STORE_BITS = (K - 1) * COL_BITS;

      logic [SW-1:0] s_q, s_d;
      logic [XW-1:0] x_q, x_d;
      logic [YW-1:0] y_q, y_d;
      logic [AW-1:0] a_q, a_d;

      logic [(K-1)*PIX-1:0] lb_mem [LB_DEPTH];
      logic [(K-1)*PIX-1:0] lb_rd_q;
      logic [(K-1)*PIX-1:0] lb_wr;
      logic [STORE_BITS-1:0] cs_mem [SF];
      logic [STORE_BITS-1:0] cs_rd_q;
      logic [STORE_BITS-1:0] cs_wr;
      logic [COL_BITS-1:0]   col;
      logic [K*K*PIX-1:0]    full;
      logic [K*K*PIX-1:0]    win_raw;

      always_comb begin
        s_d = s_q;
        x_d = x_q;
        y_d = y_q;
        a_d = a_q;
        if (rst) begin
          s_d = '0;
          x_d = '0;
          y_d = '0;
          a_d = '0;
        end else if (accept) begin
          a_d = (a_q == AW'(LB_DEPTH - 1)) ? '0 : a_q + AW'(1);
          if (s_q == SW'(SF - 1)) begin
            s_d = '0;
            if (x_q == XW'(IFM_DIM_X - 1)) begin
              x_d = '0;
              y_d = (y_q == YW'(IFM_DIM_Y - 1)) ? '0 : y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        s_q <= s_d;
        x_q <= x_d;
        y_q <= y_d;
        a_q <= a_d;
      end

      // Pixel ky of a column sits at ky*PIX (ky=0 oldest); stored column c at c*COL_BITS.
      assign col   = {pix_in, lb_rd_q};
      assign lb_wr = col[COL_BITS-1:PIX];
      assign full  = {col, cs_rd_q};
      assign cs_wr = full[K*K*PIX-1:COL_BITS];

      // Reads are prefetched from the next-state address so the registered read
      // already holds the current position's data when its beat arrives.
      always_ff @(posedge clk) begin
        if (accept_w) begin
          lb_mem[a_q] <= lb_wr;
          cs_mem[s_q] <= cs_wr;
        end
        lb_rd_q <= lb_mem[a_d];
        cs_rd_q <= (accept_w && s_d == s_q) ? cs_wr : cs_mem[s_d];
      end

      genvar gi, gj;
      for (gi = 0; gi < K; gi++) begin : g_ky
        for (gj = 0; gj < K; gj++) begin : g_kx
          assign win_raw[(gi*K+gj)*PIX +: PIX] = full[(gj*K+gi)*PIX +: PIX];
        end
      end

      assign window = OUT_BITS'(win_raw);
      assign emit   = accept_w && (y_q >= YW'(K - 1)) && (x_q >= XW'(K - 1));
    end
  endgenerate
endmodule
